// File: rtl/rv_pkg.sv
// rv_pkg: shared register-file widths and requester identifiers for write-back arbitration.
package rv_pkg;
    localparam int XLEN = 32;
    localparam int AW = 5;
    localparam int NREG = 2 ** AW;
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LSU = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2
    import rv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    logic last;

    assign grant[REQ_ALU] = valid[REQ_ALU] && (!valid[REQ_LSU] || last == REQ_LSU);
    assign grant[REQ_LSU] = valid[REQ_LSU] && (!valid[REQ_ALU] || last == REQ_ALU);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last <= REQ_LSU;
        else if (|grant)
            last <= grant[REQ_LSU];
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between ALU and load unit
// and tracks registers with issued-but-unwritten results for hazard stalls.
module rf_wb_arbiter #(
    parameter int XLEN = rv_pkg::XLEN,
    parameter int AW   = rv_pkg::AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              req0_valid,
    input  logic [AW-1:0]     req0_rd,
    input  logic [XLEN-1:0]   req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [AW-1:0]     req1_rd,
    input  logic [XLEN-1:0]   req1_data,
    output logic              req1_ready,
    output logic              WE3,
    output logic [AW-1:0]     A3,
    output logic [XLEN-1:0]   WD3,
    input  logic [AW-1:0]     qa1,
    input  logic [AW-1:0]     qa2,
    output logic              hz1,
    output logic              hz2,
    output logic [2**AW-1:0]  busy_mask,
    output logic              err
);
    localparam int NREG = 2 ** AW;

    logic [1:0]      grant;
    logic            xfer;
    logic            wr;
    logic [AW-1:0]   x_rd;
    logic [XLEN-1:0] x_data;
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[rv_pkg::REQ_ALU];
    assign req1_ready = grant[rv_pkg::REQ_LSU];
    assign xfer       = |grant;
    assign x_rd       = grant[rv_pkg::REQ_LSU] ? req1_rd : req0_rd;
    assign x_data     = grant[rv_pkg::REQ_LSU] ? req1_data : req0_data;
    assign wr         = xfer && x_rd != '0;

    // Bit 0 is never set, so x0 never reads as pending.
    assign hz1       = pend[qa1] && qa1 != '0;
    assign hz2       = pend[qa2] && qa2 != '0;
    assign busy_mask = pend;

    // Issue is applied after the clear: a younger writer keeps the register pending.
    always_comb begin
        pend_nxt = pend;
        if (wr)
            pend_nxt[x_rd] = 1'b0;
        if (iss_valid && iss_rd != '0)
            pend_nxt[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WE3  <= 1'b0;
            A3   <= '0;
            WD3  <= '0;
            pend <= '0;
            err  <= 1'b0;
        end else begin
            WE3 <= wr;
            if (xfer) begin
                A3  <= x_rd;
                WD3 <= x_data;
            end
            pend <= pend_nxt;
            err  <= err || (wr && !pend[x_rd]);
        end
    end
endmodule
